// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
// Bundles the three buses that meet at the data-memory arbiter:
//   cpu_*  : MEM-stage request (req/we/addr/wdata) and its response (rdata/stall)
//   dma_*  : DMA/loader request (req/we/lock/addr/wdata) and its response
//            (gnt/rdata/rvalid)
//   ram_*  : single-ported data RAM (we/addr/wdata out, combinational rdata in)
// Modports:
//   slave  : the arbiter itself, which serves CPU and DMA and drives the RAM
//   master : the surroundings (pipeline, DMA engine, RAM model)
interface dmem_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;

  logic        dma_req;
  logic        dma_we;
  logic        dma_lock;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_gnt;
  logic [31:0] dma_rdata;
  logic        dma_rvalid;

  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
    output dma_gnt, dma_rdata, dma_rvalid,
    output ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
    input  dma_gnt, dma_rdata, dma_rvalid,
    input  ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single-ported data RAM between the MEM stage and a DMA/loader.
// The CPU has priority; a saturating starvation counter forces one DMA slot
// after MAX_WAIT denied cycles, and a locked DMA burst may own the port for
// up to MAX_BURST consecutive beats. Whenever the DMA takes the port while the
// CPU is requesting, cpu_stall freezes the pipeline for that cycle.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : dmem_arbiter_if.slave (CPU, DMA and RAM signals)
// Parameters:
//   MAX_WAIT  : denied DMA cycles before DMA is forced over the CPU (>=1)
//   MAX_BURST : maximum beats in one locked DMA burst (>=2)
module dmem_arbiter #(
  parameter int MAX_WAIT  = 3,
  parameter int MAX_BURST = 4
) (
  input  logic            clock,
  input  logic            reset,
  dmem_arbiter_if.slave   bus
);

  localparam int SW = $clog2(MAX_WAIT + 1);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_WAIT);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  typedef enum logic {
    CPU_PRI,
    BURST
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [SW-1:0] starve_cnt;
  logic [SW-1:0] starve_next;
  logic [BW-1:0] burst_cnt;
  logic [BW-1:0] burst_next;
  logic          dma_gnt;
  logic [31:0]   dma_rdata_q;
  logic          dma_rvalid_q;

  // DMA wins when it owns a burst, when the CPU is idle, or when it has been
  // starved long enough. Gated by reset so nothing reaches the RAM in reset.
  assign dma_gnt = bus.dma_req & ~reset &
                   ((state == BURST) | ~bus.cpu_req | (starve_cnt == STARVE_MAX));

  assign bus.dma_gnt    = dma_gnt;
  assign bus.cpu_stall  = bus.cpu_req & dma_gnt;
  assign bus.cpu_rdata  = bus.ram_rdata;
  assign bus.dma_rdata  = dma_rdata_q;
  assign bus.dma_rvalid = dma_rvalid_q;

  // A stalled CPU store is dropped here because the DMA owns the mux; the
  // pipeline holds the store and it commits once the stall releases.
  always_comb begin
    bus.ram_addr  = bus.cpu_addr;
    bus.ram_wdata = bus.cpu_wdata;
    bus.ram_we    = bus.cpu_req & bus.cpu_we & ~reset;
    if (dma_gnt) begin
      bus.ram_addr  = bus.dma_addr;
      bus.ram_wdata = bus.dma_wdata;
      bus.ram_we    = bus.dma_we;
    end
  end

  // Next-state logic for the burst FSM, its beat counter and the starvation
  // counter. Inside BURST a present request is always granted, so every
  // cycle that stays in BURST is a beat.
  always_comb begin
    state_next  = state;
    burst_next  = burst_cnt;
    starve_next = starve_cnt;

    if (dma_gnt || !bus.dma_req) begin
      starve_next = '0;
    end else if (starve_cnt != STARVE_MAX) begin
      starve_next = starve_cnt + SW'(1);
    end

    case (state)
      CPU_PRI: begin
        if (dma_gnt && bus.dma_lock) begin
          state_next = BURST;
          burst_next = BW'(1);
        end
      end
      BURST: begin
        if (!bus.dma_req || !bus.dma_lock ||
            (dma_gnt && (burst_cnt == BURST_LAST))) begin
          state_next = CPU_PRI;
          burst_next = '0;
        end else if (dma_gnt) begin
          burst_next = burst_cnt + BW'(1);
        end
      end
      default: begin
        state_next = CPU_PRI;
        burst_next = '0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= CPU_PRI;
      starve_cnt <= '0;
      burst_cnt  <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_next;
      burst_cnt  <= burst_next;
    end
  end

  // DMA read data is captured at the end of its grant cycle; reset discards
  // any read still in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dma_rdata_q  <= '0;
      dma_rvalid_q <= 1'b0;
    end else if (dma_gnt && !bus.dma_we) begin
      dma_rdata_q  <= bus.ram_rdata;
      dma_rvalid_q <= 1'b1;
    end else begin
      dma_rvalid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Directed bench for dmem_arbiter with MAX_WAIT=3 and MAX_BURST=4. A small
// word-addressed RAM model (rising-edge write, combinational read) sits on
// the RAM side. Inputs change 1 time unit after a rising edge; outputs are
// sampled a further time unit later, well away from the next edge.
module tb_dmem_arbiter;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_fail;

  dmem_arbiter_if bus ();

  dmem_arbiter #(
    .MAX_WAIT  (3),
    .MAX_BURST (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [0:63];

  // RAM model: cleared while reset is high, written on rising edges.
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
    end else if (bus.ram_we) begin
      mem[bus.ram_addr[7:2]] <= bus.ram_wdata;
    end
  end

  assign bus.ram_rdata = mem[bus.ram_addr[7:2]];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_cpu(input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
    bus.cpu_req   = req;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
  endtask

  task automatic set_dma(input logic req, input logic we, input logic lock,
                         input logic [31:0] addr, input logic [31:0] wdata);
    bus.dma_req   = req;
    bus.dma_we    = we;
    bus.dma_lock  = lock;
    bus.dma_addr  = addr;
    bus.dma_wdata = wdata;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b1;
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    set_dma(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();

    // Outputs forced quiet while reset is high, even with both sides asking.
    set_cpu(1'b1, 1'b1, 32'h10, 32'h1111_1111);
    set_dma(1'b1, 1'b1, 1'b0, 32'h14, 32'h2222_2222);
    #1;
    check_output("rst_gnt",    {31'b0, bus.dma_gnt},    32'd0);
    check_output("rst_stall",  {31'b0, bus.cpu_stall},  32'd0);
    check_output("rst_ram_we", {31'b0, bus.ram_we},     32'd0);
    check_output("rst_rvalid", {31'b0, bus.dma_rvalid}, 32'd0);
    check_output("rst_rdata",  bus.dma_rdata,           32'd0);
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    set_dma(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    reset = 1'b0;

    // CPU only: store then load 0x10, never stalled.
    set_cpu(1'b1, 1'b1, 32'h10, 32'hA5A5_A5A5);
    #1;
    check_output("cpu_st_stall", {31'b0, bus.cpu_stall}, 32'd0);
    check_output("cpu_st_we",    {31'b0, bus.ram_we},    32'd1);
    check_output("cpu_st_addr",  bus.ram_addr,           32'h10);
    tick();
    set_cpu(1'b1, 1'b0, 32'h10, 32'h0);
    #1;
    check_output("cpu_ld_stall", {31'b0, bus.cpu_stall}, 32'd0);
    check_output("cpu_ld_data",  bus.cpu_rdata,          32'hA5A5_A5A5);
    check_output("cpu_ld_we",    {31'b0, bus.ram_we},    32'd0);
    tick();
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);

    // DMA only: same-cycle grant, registered data one cycle later.
    set_dma(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    #1;
    check_output("dma_rd_gnt",  {31'b0, bus.dma_gnt}, 32'd1);
    check_output("dma_rd_addr", bus.ram_addr,         32'h10);
    check_output("dma_rd_we",   {31'b0, bus.ram_we},  32'd0);
    tick();
    set_dma(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check_output("dma_rvalid",  {31'b0, bus.dma_rvalid}, 32'd1);
    check_output("dma_rdata",   bus.dma_rdata,           32'hA5A5_A5A5);
    check_output("dma_idle_gnt", {31'b0, bus.dma_gnt},   32'd0);
    tick();
    #1;
    check_output("dma_rvalid_drop", {31'b0, bus.dma_rvalid}, 32'd0);
    check_output("dma_rdata_hold",  bus.dma_rdata,           32'hA5A5_A5A5);

    // Starvation: three CPU cycles, then a forced DMA slot, repeating.
    set_cpu(1'b1, 1'b0, 32'h10, 32'h0);
    set_dma(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) begin
        #1;
        check_output($sformatf("starve_gnt_r%0d_c%0d", r, c),
                     {31'b0, bus.dma_gnt}, (c == 3) ? 32'd1 : 32'd0);
        check_output($sformatf("starve_stall_r%0d_c%0d", r, c),
                     {31'b0, bus.cpu_stall}, (c == 3) ? 32'd1 : 32'd0);
        tick();
      end
    end
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    set_dma(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // Locked write burst: entry with CPU idle, then CPU requests. Four beats,
    // stall on beats 2-4, then the CPU gets a cycle.
    for (int b = 0; b < 4; b++) begin
      set_dma(1'b1, 1'b1, 1'b1, 32'h40 + 32'(4 * b), 32'h1000 + 32'(b));
      if (b > 0) set_cpu(1'b1, 1'b0, 32'h10, 32'h0);
      #1;
      check_output($sformatf("burst_gnt_b%0d", b + 1), {31'b0, bus.dma_gnt}, 32'd1);
      check_output($sformatf("burst_stall_b%0d", b + 1), {31'b0, bus.cpu_stall},
                   (b > 0) ? 32'd1 : 32'd0);
      check_output($sformatf("burst_we_b%0d", b + 1), {31'b0, bus.ram_we}, 32'd1);
      check_output($sformatf("burst_addr_b%0d", b + 1), bus.ram_addr,
                   32'h40 + 32'(4 * b));
      tick();
    end
    set_dma(1'b1, 1'b1, 1'b1, 32'h50, 32'h1004);
    #1;
    check_output("post_burst_gnt",   {31'b0, bus.dma_gnt},   32'd0);
    check_output("post_burst_stall", {31'b0, bus.cpu_stall}, 32'd0);
    check_output("post_burst_rdata", bus.cpu_rdata,          32'hA5A5_A5A5);
    tick();
    set_dma(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    set_cpu(1'b1, 1'b0, 32'h4C, 32'h0);
    #1;
    check_output("burst_last_word", bus.cpu_rdata, 32'h1003);
    tick();

    // Stalled store: CPU loads for three cycles while DMA waits, then a CPU
    // store of 0xDEADBEEF to 0x20 meets the forced DMA read.
    set_dma(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    for (int c = 0; c < 3; c++) begin
      set_cpu(1'b1, 1'b0, 32'h10, 32'h0);
      tick();
    end
    set_cpu(1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF);
    #1;
    check_output("blk_gnt",   {31'b0, bus.dma_gnt},   32'd1);
    check_output("blk_stall", {31'b0, bus.cpu_stall}, 32'd1);
    check_output("blk_ram_we", {31'b0, bus.ram_we},   32'd0);
    check_output("blk_addr",  bus.ram_addr,           32'h10);
    tick();
    set_dma(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check_output("blk_mem_unchanged", mem[8],              32'h0);
    check_output("blk_dma_rvalid", {31'b0, bus.dma_rvalid}, 32'd1);
    check_output("blk_dma_rdata",  bus.dma_rdata,          32'hA5A5_A5A5);
    check_output("blk_retry_stall", {31'b0, bus.cpu_stall}, 32'd0);
    check_output("blk_retry_we",   {31'b0, bus.ram_we},    32'd1);
    check_output("blk_retry_wdata", bus.ram_wdata,         32'hDEAD_BEEF);
    tick();
    set_cpu(1'b1, 1'b0, 32'h20, 32'h0);
    #1;
    check_output("blk_commit", bus.cpu_rdata, 32'hDEAD_BEEF);
    tick();
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // Reset pulsed during beat 2 of a locked read burst.
    set_dma(1'b1, 1'b0, 1'b1, 32'h40, 32'h0);
    #1;
    check_output("rb_beat1_gnt", {31'b0, bus.dma_gnt}, 32'd1);
    tick();
    set_dma(1'b1, 1'b0, 1'b1, 32'h44, 32'h0);
    #1;
    check_output("rb_beat2_gnt",   {31'b0, bus.dma_gnt},    32'd1);
    check_output("rb_beat1_rdata", bus.dma_rdata,           32'h1000);
    #1;
    reset = 1'b1;
    #1;
    check_output("rb_rst_gnt",    {31'b0, bus.dma_gnt},    32'd0);
    check_output("rb_rst_rvalid", {31'b0, bus.dma_rvalid}, 32'd0);
    tick();
    set_cpu(1'b1, 1'b0, 32'h10, 32'h0);
    set_dma(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      check_output($sformatf("rb_after_gnt_c%0d", c),
                   {31'b0, bus.dma_gnt}, (c == 3) ? 32'd1 : 32'd0);
      if (c == 0)
        check_output("rb_after_rvalid", {31'b0, bus.dma_rvalid}, 32'd0);
      tick();
    end
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    set_dma(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-ported data memory between the pipeline's MEM stage and a DMA/loader port. CPU accesses have priority. A starvation counter forces a DMA slot after `MAX_WAIT` denied cycles, and a locked DMA burst may hold the port for up to `MAX_BURST` beats. Whenever the CPU loses the port it gets `cpu_stall`, which freezes PC, IR and all stage registers for that cycle. The block sits between the MEM stage and the data RAM; the RAM has a rising-edge write and a combinational read.

## Interface
- `MAX_WAIT`, default 3: consecutive denied DMA cycles before DMA is forced over the CPU (≥1).
- `MAX_BURST`, default 4: maximum consecutive beats in one locked DMA burst (≥2).
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `cpu_req` in 1: MEM stage wants memory (load or store).
- `cpu_we` in 1: MEM-stage store.
- `cpu_addr` in 32: MEM-stage address (ALU result).
- `cpu_wdata` in 32: MEM-stage store data.
- `cpu_rdata` out 32: load data to MEM/WB register.
- `cpu_stall` out 1: pipeline freeze for this cycle.
- `dma_req` in 1: DMA access request.
- `dma_we` in 1: DMA write.
- `dma_lock` in 1: request burst ownership.
- `dma_addr` in 32: DMA address.
- `dma_wdata` in 32: DMA write data.
- `dma_gnt` out 1: DMA beat performed this cycle.
- `dma_rdata` out 32: registered DMA read data.
- `dma_rvalid` out 1: `dma_rdata` valid.
- `ram_we` out 1: RAM write enable.
- `ram_addr` out 32: RAM address.
- `ram_wdata` out 32: RAM write data.
- `ram_rdata` in 32: RAM combinational read data.

## Operation
- **States:** `CPU_PRI` (reset) and `BURST`.
- **Counters:** `starve_cnt`, 0..`MAX_WAIT`, saturating. `burst_cnt` counts granted beats in the current burst. Both reset to 0.
- **Grant (combinational):** `dma_gnt = dma_req & !reset & (state==BURST | !cpu_req | starve_cnt==MAX_WAIT)`.
- **CPU stall:** `cpu_stall = cpu_req & dma_gnt`. A stalled CPU keeps `cpu_req`, `cpu_addr` and `cpu_wdata` stable.
- **RAM mux:**
  - When `dma_gnt`: `ram_addr`/`ram_wdata` = `dma_addr`/`dma_wdata`, and `ram_we = dma_we`.
  - Otherwise: `ram_addr`/`ram_wdata` = the CPU values, and `ram_we = cpu_req & cpu_we & !reset`.
  - A stalled CPU store never reaches the RAM.
- **CPU read data:** `cpu_rdata = ram_rdata` at all times. It is meaningful only when `cpu_req & !cpu_stall`.
- **DMA read data:** on a clock edge where `dma_gnt & !dma_we`, `dma_rdata <= ram_rdata` and `dma_rvalid <= 1`. On any other edge `dma_rvalid <= 0` and `dma_rdata` holds.
- **`starve_cnt` update each edge:**
  - `dma_gnt` → 0.
  - `dma_req & !dma_gnt` → +1, saturating at `MAX_WAIT`.
  - `!dma_req` → 0.
- **`CPU_PRI` → `BURST`** when `dma_gnt & dma_lock`; `burst_cnt <= 1`.
- **In `BURST`:** each `dma_gnt` beat does `burst_cnt <= burst_cnt+1`.
- **`BURST` → `CPU_PRI`** on an edge where any of these holds (`burst_cnt <= 0`):
  - `!dma_req`;
  - `!dma_lock`;
  - `dma_gnt & burst_cnt==MAX_BURST-1` (the `MAX_BURST`th beat is the last one).
- **After a burst ends:** the next cycle is `CPU_PRI` with `starve_cnt`=0, so a waiting CPU always wins at least one cycle.
- **`dma_lock` with no conflict:** still enters `BURST`; the burst limit still applies.

## Timing
- **Reset values:** `state`=`CPU_PRI`, `starve_cnt`=0, `burst_cnt`=0, `dma_rdata`=0, `dma_rvalid`=0.
- **Outputs while `reset` is high:** `dma_gnt`=0, `cpu_stall`=0, `ram_we`=0.
- **Latency:** CPU access is zero-wait when granted. DMA read data appears 1 cycle after the `dma_gnt` cycle. A DMA write completes at the edge ending its `dma_gnt` cycle.
- **DMA handshake:** the DMA holds `req`/`we`/`addr`/`wdata` stable until it samples `dma_gnt`=1. It may change them or drop `req` in the cycle after.
- **Worst-case DMA wait:** `MAX_WAIT` cycles, then the grant arrives in cycle `MAX_WAIT`+1.
- **Worst-case CPU stall:** `MAX_BURST` consecutive cycles.
- **Reset mid-burst:** returns immediately to `CPU_PRI`. Any in-flight `dma_rvalid` is cleared and the pending read data is lost.
- **Simultaneous `cpu_req` and `dma_req` with `starve_cnt<MAX_WAIT` in `CPU_PRI`:** the CPU wins and there is no stall.

## Test plan
- **CPU only:** `cpu_req`=1, `cpu_we`=1, addr 0x10, data 0xA5A5A5A5, then a load of 0x10. Required: `cpu_stall` never asserted, `cpu_rdata`=0xA5A5A5A5 in the load cycle.
- **DMA only:** `dma_req`=1, `dma_we`=0, addr 0x10. Required: `dma_gnt`=1 in the same cycle, `dma_rvalid`=1 with `dma_rdata`=0xA5A5A5A5 the next cycle.
- **Starvation, `MAX_WAIT`=3:** `cpu_req` and `dma_req` held high. Required: `dma_gnt` low for 3 cycles, high with `cpu_stall`=1 in the 4th, then CPU served for 3 cycles, repeating.
- **Burst, `MAX_BURST`=4:** `dma_lock`=1, `dma_req`=1, `cpu_req`=0 entry, then `cpu_req`=1. Required: 4 consecutive DMA beats with `cpu_stall` high for beats 2–4, then one CPU cycle with no stall.
- **Stalled store blocked:** a conflict cycle where a forced DMA read coincides with a CPU store of 0xDEADBEEF to 0x20. Required: `ram_we`=0, address 0x20 unchanged that cycle, the store commits the next cycle.
- **Reset mid-burst:** `reset` pulsed in beat 2 of a read burst. Required: `dma_gnt`=0 and `dma_rvalid`=0 immediately, and `CPU_PRI` with counters at 0 after release.
